// File: rtl/booth_mult.sv
// Radix-2 Booth 32x32 signed multiplier, one step per clock.
// Level-held request/done handshake; HI/LO held until the next product.
module booth_mult (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RegAOut,
    input  logic [31:0] RegBOut,
    input  logic        multCtrl,
    output logic        multDone,
    output logic        multBusy,
    output logic [31:0] MultHIOut,
    output logic [31:0] MultLOOut
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_n;
    logic [32:0] m, acc, sum, acc_sh;
    logic [31:0] q, q_sh;
    logic        q_1;
    logic [5:0]  cnt;
    logic        load, step;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        multDone = 1'b0;
        multBusy = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (multCtrl) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                multBusy = 1'b1;
                if (!multCtrl) begin
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == 6'd31) state_n = DONE;
                end
            end
            DONE: begin
                multDone = 1'b1;
                if (!multCtrl) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // 33-bit add/sub so that M = -2^31 is represented exactly
    always_comb begin
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_sh = {sum[32], sum[32:1]};
        q_sh   = {sum[0], q[31:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m         <= '0;
            acc       <= '0;
            q         <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
            MultHIOut <= '0;
            MultLOOut <= '0;
        end else if (load) begin
            m   <= {RegAOut[31], RegAOut};
            acc <= '0;
            q   <= RegBOut;
            q_1 <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_sh;
            q   <= q_sh;
            q_1 <= q[0];
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
                MultHIOut <= acc_sh[31:0];
                MultLOOut <= q_sh;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult against an arithmetic product model.
// Directed handshake/reset/abort cases plus randomized operands.
module tb_booth_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] RegAOut;
    logic [31:0] RegBOut;
    logic        multCtrl;
    logic        multDone;
    logic        multBusy;
    logic [31:0] MultHIOut;
    logic [31:0] MultLOOut;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    booth_mult dut (
        .clock     (clock),
        .reset     (reset),
        .RegAOut   (RegAOut),
        .RegBOut   (RegBOut),
        .multCtrl  (multCtrl),
        .multDone  (multDone),
        .multBusy  (multBusy),
        .MultHIOut (MultHIOut),
        .MultLOOut (MultLOOut)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input bit scramble, input int hold);
        logic [63:0] exp, prev;
        int n;
        exp      = model(a, b);
        prev     = {MultHIOut, MultLOOut};
        RegAOut  = a;
        RegBOut  = b;
        multCtrl = 1'b1;
        tick();
        if (scramble) begin
            RegAOut = $urandom;
            RegBOut = $urandom;
        end
        n = 0;
        while (!multDone && n < 40) begin
            chk("busy", {63'd0, multBusy}, 64'd1);
            chk("held_prev", {MultHIOut, MultLOOut}, prev);
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd32);
        chk("product", {MultHIOut, MultLOOut}, exp);
        chk("busy_done", {63'd0, multBusy}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_done", {63'd0, multDone}, 64'd1);
            chk("hold_busy", {63'd0, multBusy}, 64'd0);
            chk("hold_prod", {MultHIOut, MultLOOut}, exp);
        end
        multCtrl = 1'b0;
        tick();
        chk("done_fall", {63'd0, multDone}, 64'd0);
        chk("idle_prod", {MultHIOut, MultLOOut}, exp);
    endtask

    initial begin
        reset    = 1'b1;
        multCtrl = 1'b0;
        RegAOut  = '0;
        RegBOut  = '0;
        tick();
        tick();
        chk("rst_done", {63'd0, multDone}, 64'd0);
        chk("rst_busy", {63'd0, multBusy}, 64'd0);
        chk("rst_prod", {MultHIOut, MultLOOut}, 64'd0);

        // reset wins over a simultaneous request
        RegAOut  = 32'd9;
        RegBOut  = 32'd9;
        multCtrl = 1'b1;
        tick();
        chk("rst_req_busy", {63'd0, multBusy}, 64'd0);
        reset    = 1'b0;
        multCtrl = 1'b0;
        tick();

        run_mult(32'd3, 32'd5, 1'b0, 0);
        chk("3x5_lo", {32'd0, MultLOOut}, 64'h0F);
        run_mult(32'hFFFFFFF9, 32'h00000006, 1'b0, 0);
        chk("m7x6", {MultHIOut, MultLOOut}, 64'hFFFFFFFF_FFFFFFD6);
        run_mult(32'h80000000, 32'h80000000, 1'b0, 0);
        chk("min_sq", {MultHIOut, MultLOOut}, 64'h40000000_00000000);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        chk("neg1_sq", {MultHIOut, MultLOOut}, 64'h1);
        run_mult(32'h7FFFFFFF, 32'h80000000, 1'b0, 0);
        chk("max_min", {MultHIOut, MultLOOut}, 64'hC0000000_80000000);

        // reset during the 10th RUN cycle
        RegAOut  = 32'd12;
        RegBOut  = 32'd12;
        multCtrl = 1'b1;
        tick();
        repeat (9) tick();
        reset    = 1'b1;
        multCtrl = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {63'd0, multBusy}, 64'd0);
        chk("midrst_done", {63'd0, multDone}, 64'd0);
        chk("midrst_prod", {MultHIOut, MultLOOut}, 64'd0);
        tick();
        run_mult(32'd2, 32'd2, 1'b0, 0);
        chk("2x2_lo", {32'd0, MultLOOut}, 64'd4);

        // abort at RUN cycle 5
        RegAOut  = 32'd100;
        RegBOut  = 32'd100;
        multCtrl = 1'b1;
        tick();
        repeat (4) tick();
        multCtrl = 1'b0;
        tick();
        chk("abort_busy", {63'd0, multBusy}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_done", {63'd0, multDone}, 64'd0);
            chk("abort_prod", {MultHIOut, MultLOOut}, 64'd4);
            tick();
        end
        run_mult(32'd100, 32'd100, 1'b1, 0);
        chk("scramble_lo", {MultHIOut, MultLOOut}, 64'h2710);

        // long hold in DONE must not restart
        run_mult(32'hFFFF1234, 32'h00ABCDEF, 1'b0, 20);

        for (int i = 0; i < 12; i++) begin
            run_mult($urandom, $urandom, i[0], i % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential 32x32 signed multiplier for the multicycle MIPS datapath, implementing `mult` with radix-2 Booth recoding at one iteration per clock. The control unit starts it through a level-held request/done handshake. It returns the 64-bit product split into HI (upper word) and LO (lower word). Those words feed the HI/LO registers, alongside the divider that uses the same handshake style.

## Interface
Parameters:
- none; the width is fixed at 32 bits and the iteration count at 32.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- RegAOut  in  32  multiplicand (rs), two's complement
- RegBOut  in  32  multiplier (rt), two's complement
- multCtrl  in  1  request level from the control unit; held high until multDone is seen
- multDone  out  1  product valid; high in DONE state only
- multBusy  out  1  high while in RUN state
- MultHIOut  out  32  product bits [63:32]
- MultLOOut  out  32  product bits [31:0]

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: Booth iterations in progress.
  - DONE: product valid and held.
- Internal registers:
  - M: 33 bits, sign-extended multiplicand.
  - ACC: 33 bits, accumulator.
  - Q: 32 bits, multiplier/low product.
  - Q_1: 1 bit.
  - CNT: 6 bits.
- IDLE, multCtrl=1:
  - M <= sext(RegAOut); ACC <= 0; Q <= RegBOut; Q_1 <= 0; CNT <= 0.
  - Go to RUN.
- RUN, each cycle (one Booth step):
  - {Q[0],Q_1}=01: ACC <= ACC+M.
  - {Q[0],Q_1}=10: ACC <= ACC−M.
  - 00 or 11: ACC unchanged.
  - Then arithmetic right shift of {ACC,Q,Q_1} by 1; ACC[32] is replicated.
  - CNT <= CNT+1.
  - The add/subtract result feeds the shift in the same cycle.
- RUN exit:
  - On the step with CNT=31, register MultHIOut <= shifted ACC[31:0] and MultLOOut <= shifted Q.
  - Go to DONE.
- DONE:
  - multDone=1; outputs held.
  - Stay while multCtrl=1.
  - multCtrl=0: go to IDLE.
- Arithmetic:
  - The 33-bit accumulator makes M=0x80000000 exact (−2^31 × −2^31 = 2^62).
  - The product is the exact 64-bit signed result; there is no overflow case and no exception output.
- Operands are sampled only on the IDLE→RUN edge; later changes on RegAOut/RegBOut are ignored.
- MultHIOut/MultLOOut change only on the RUN→DONE edge or on reset. They keep the last product through IDLE and RUN of the next operation.

## Timing
- Reset values (after a reset edge):
  - State=IDLE.
  - multDone=0, multBusy=0.
  - MultHIOut=0, MultLOOut=0.
  - ACC, Q, Q_1, CNT, M = 0.
- Reset has priority over every transition, including mid-RUN and DONE. Any partial product is discarded.
- Latency: if multCtrl is sampled high on edge E0, multDone is high after edge E32 (32 cycles), together with valid outputs.
- multBusy is high from after E0 through edge E32.
- multCtrl dropped during RUN: abort to IDLE on that edge.
  - Outputs are not updated; multDone never pulses.
  - The next request restarts from operand load.
- multCtrl dropped in DONE: multDone falls after the next edge.
- A new request needs at least one IDLE cycle. multCtrl held high continuously therefore never re-triggers from DONE.
- multCtrl=1 and reset=1 on the same edge: reset wins, state=IDLE, no load.

## Test plan
- 3 × 5, multCtrl held until done:
  - multDone rises exactly 32 cycles after the load edge.
  - HI=0x00000000, LO=0x0000000F.
- −7 × 6 (0xFFFFFFF9 × 0x00000006):
  - HI=0xFFFFFFFF, LO=0xFFFFFFD6.
- 0x80000000 × 0x80000000:
  - HI=0x40000000, LO=0x00000000.
  - Then 0xFFFFFFFF × 0xFFFFFFFF: HI=0, LO=1.
  - Then 0x7FFFFFFF × 0x80000000: HI=0xC0000000, LO=0x80000000.
- Reset mid-operation:
  - Start 12 × 12; assert reset on the 10th RUN cycle.
  - Next cycle: IDLE, multBusy=0, multDone=0, HI=LO=0.
  - A following 2 × 2 completes in 32 cycles with LO=4.
- Abort and operand stability:
  - Start 100 × 100, drop multCtrl at RUN cycle 5.
  - multDone stays 0 and outputs keep their prior value.
  - Restart, then change RegAOut/RegBOut one cycle after load: result is still 10000 (LO=0x00002710).
- Handshake hold:
  - Keep multCtrl high 20 cycles after done: multDone stays 1, outputs stable, no restart.
  - Drop multCtrl: multDone=0 on the next edge.
